// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide for the execute stage.
// Optional MULDIV_FAST_MUL_EN: MUL/MULH/MULHSU/MULHU finish in one cycle via a 33x33 signed multiply.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            m_busy,
    output logic            m_done
);

    // state | meaning
    // IDLE  | waiting for an M-op; the issue cycle latches operands
    // BUSY  | one shift-add or restoring-divide iteration per cycle
    // DONE  | result valid, m_done pulse, start ignored
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic            is_div, div_zero, div_ovf;
    logic [XLEN-1:0] a_abs, b_abs;

    always_comb begin
        a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                   (funct3 == F_DIV)  || (funct3 == F_REM);
        b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        a_abs    = a_neg ? -op_a : op_a;
        b_abs    = b_neg ? -op_b : op_b;
        is_div   = funct3[2];
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    end

    // Iteration datapath: acc holds {hi, lo} for multiply and the dividend/quotient in lo for divide
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, prod_fix;
    logic [XLEN:0]     rem_sh, rem_diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_next, quo_next, quo_fix, rem_fix;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        prod_fix = neg_q ? -mul_next : mul_next;
        rem_sh   = {rem_q, acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opd_q};
        q_bit    = ~rem_diff[XLEN];
        rem_next = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_next = {acc_q[XLEN-2:0], q_bit};
        quo_fix  = neg_q ? -quo_next : quo_next;
        rem_fix  = neg_q ? -rem_next : rem_next;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fm_a, fm_b;
    logic signed [2*XLEN-1:0] fm_p;
    logic [XLEN-1:0]          fm_res;

    always_comb begin
        fm_a   = $signed({a_signed & op_a[XLEN-1], op_a});
        fm_b   = $signed({b_signed & op_b[XLEN-1], op_b});
        fm_p   = (2*XLEN)'(fm_a) * (2*XLEN)'(fm_b);
        fm_res = (funct3 == F_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        opd_d    = opd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        m_busy   = 1'b0;
        m_done   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    m_busy = 1'b1;
                    f3_d   = funct3;
                    neg_d  = (funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);
                    cnt_d  = 5'd31;
                    rem_d  = '0;
                    if (is_div) begin
                        opd_d = b_abs;
                        acc_d = {{XLEN{1'b0}}, a_abs};
                    end else begin
                        opd_d = a_abs;
                        acc_d = {{XLEN{1'b0}}, b_abs};
                    end
                    if (div_zero) begin
                        result_d = funct3[1] ? op_a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d  = S_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        result_d = fm_res;
                        state_d  = S_DONE;
                    end
`endif
                    else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                m_busy = 1'b1;
                acc_d  = f3_q[2] ? {acc_q[2*XLEN-1:XLEN], quo_next} : mul_next;
                rem_d  = rem_next;
                if (cnt_q == 5'd0) begin
                    state_d = S_DONE;
                    if (f3_q[2])
                        result_d = f3_q[1] ? rem_fix : quo_fix;
                    else
                        result_d = (f3_q == F_MUL) ? prod_fix[XLEN-1:0]
                                                   : prod_fix[2*XLEN-1:XLEN];
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DONE: begin
                m_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flushed op never writes its result
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            opd_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic/timing model plus directed vectors.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic        m_busy, m_done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    int          m_left = 0;
    bit          m_dn   = 1'b0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .result (result),
        .m_busy (m_busy),
        .m_done (m_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        p  = '0;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
        if (f[2]) begin
            if (b == 32'd0) return 1;
            if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return MUL_LAT;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Timing model: an accepted op completes lat cycles after issue unless flushed or reset
    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_dn   <= 1'b0;
            m_res  <= '0;
        end else if (flush) begin
            m_left <= 0;
            m_dn   <= 1'b0;
        end else if (m_dn) begin
            m_dn <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_dn  <= 1'b1;
                m_res <= m_pend;
            end
        end else if (start) begin
            if (lat_of(funct3, op_a, op_b) == 1) begin
                m_dn  <= 1'b1;
                m_res <= model(funct3, op_a, op_b);
            end else begin
                m_left <= lat_of(funct3, op_a, op_b) - 1;
                m_pend <= model(funct3, op_a, op_b);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                checkb("m_busy", m_busy, (m_left > 0) || (!m_dn && start && !flush));
                checkb("m_done", m_done, m_dn);
                checkb("busy_done_exclusive", m_busy & m_done, 1'b0);
                if (m_dn || m_left == 0) check("result", result, m_res);
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit pin,
                          input string name);
        int n;
        bit seen;
        if (pin) check({name, " model"}, model(f, a, b), exp);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        n      = 0;
        seen   = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (m_done) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no m_done within 40 cycles", name);
        end else begin
            check({name, " latency"}, n, lat);
            check({name, " result"}, result, exp);
        end
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV] = '{
        '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT},
        '{3'b001, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT},
        '{3'b010, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT},
        '{3'b011, 32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF, MUL_LAT},
        '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT},
        '{3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT},
        '{3'b001, 32'hFFFF_FFFA,  32'd7,         32'hFFFF_FFFF, MUL_LAT},
        '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33},
        '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33},
        '{3'b101, 32'd100,        32'd7,         32'd14,        33},
        '{3'b111, 32'd100,        32'd7,         32'd2,         33},
        '{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33},
        '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33},
        '{3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33},
        '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1},
        '{3'b111, 32'h0000_1234,  32'd0,         32'h0000_1234, 1},
        '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("reset result", result, 32'd0);
        checkb("reset m_busy", m_busy, 1'b0);
        checkb("reset m_done", m_done, 1'b0);
        @(posedge clk);
        #2;

        for (int i = 0; i < NV; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1,
                   $sformatf("vec%0d", i));

        // Flush a DIV in its tenth cycle, then issue DIVU 9/3 at T12
        funct3 = 3'b100;
        op_a   = 32'hFFFF_FF9C;
        op_b   = 32'd7;
        start  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkb("flush m_busy", m_busy, 1'b0);
        checkb("flush m_done", m_done, 1'b0);
        @(posedge clk);
        #2;
        run_op(3'b101, 32'd9, 32'd3, 32'd3, 33, 1'b1, "post_flush");

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((i == 5) ? 32'($urandom_range(1, 9)) : $urandom);
            run_op(rf, ra, rb, model(rf, ra, rb), lat_of(rf, ra, rb), 1'b0,
                   $sformatf("rand%0d", i));
        end

        // Reset in the middle of a DIVU
        funct3 = 3'b101;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        start  = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("midop reset result", result, 32'd0);
        checkb("midop reset m_busy", m_busy, 1'b0);
        checkb("midop reset m_done", m_done, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It accepts one M-extension operation from the decoded execute-stage instruction and computes it over multiple cycles. It drives `m_busy`/`m_done` into the hazard unit, which holds the pipeline stall while the operation runs. It also returns the 32-bit result to the writeback mux.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width. Only 32 is supported.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: execute-stage instruction is an M-op (opcode 0110011, funct7 0000001). Held high while the instruction sits in execute.
- `funct3`, in, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`, in, 32: rs1 value, after forwarding.
- `op_b`, in, 32: rs2 value, after forwarding.
- `flush`, in, 1: branch/interrupt flush of the execute stage.
- `result`, out, 32: final result. Valid while `m_done`=1, and holds its value until the next start.
- `m_busy`, out, 1: operation in flight (stall request).
- `m_done`, out, 1: one-cycle completion pulse.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset puts the FSM in IDLE with `m_busy`=0, `m_done`=0, `result`=0 and the iteration counter at 0.
- **IDLE**, `start`=1, `flush`=0:
  - Latch `funct3`.
  - Latch the absolute values of the operands. Signedness comes from `funct3`: signed for MULH and DIV/REM; MULHSU treats only `op_a` as signed.
  - Latch the result sign.
  - Load the counter with 31 and go to BUSY.
- **BUSY**, one iteration per cycle:
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring step on a 33-bit partial remainder.
  - When the counter reaches 0, apply sign correction, register `result` and go to DONE. Otherwise decrement the counter.
- **DONE**:
  - `m_done`=1 for exactly this cycle.
  - `start` is ignored here, because the same instruction is still in execute.
  - Next state is IDLE.
- Result selection:
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide by zero (`op_b`=0), detected in IDLE:
  - Skip BUSY and go directly to DONE.
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return `op_a`.
- Signed overflow (DIV or REM with `op_a`=0x80000000 and `op_b`=0xFFFFFFFF), detected in IDLE:
  - Go directly to DONE.
  - DIV returns 0x80000000; REM returns 0.
- `m_busy` = (state==BUSY) | (state==IDLE & `start` & ~`flush`). It is combinational so the stall covers the issue cycle. It is 0 in DONE.
- `flush` in any state forces IDLE next cycle. No `m_done` is produced, and `result` keeps its old value.
- `reset` mid-operation behaves like `flush` and additionally clears `result`.

## Timing
- The issue cycle is T0 (IDLE with `start`=1).
- Iterative operations:
  - BUSY occupies T1..T32.
  - DONE and `m_done` occur at T33.
  - `m_busy`=1 for T0..T32 (33 cycles).
- Divide-by-zero and overflow: DONE at T1, with `m_busy`=1 at T0 only.
- Back-to-back M-ops:
  - The next instruction reaches execute no earlier than T34, when the FSM is in IDLE, and it is accepted there.
  - There is no dead cycle beyond DONE.
- `m_busy` and `m_done` are never both 1 in the same cycle.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL, MULH, MULHSU and MULHU use a single-cycle 33x33 signed multiply, registered in IDLE.
  - These ops go directly to DONE at T1, with `m_busy` only at T0.
  - Divide ops are unchanged.
- `MULDIV_FAST_MUL_EN` undefined: all multiply ops use the 32-iteration shift-add path, with `m_done` at T33.

## Test plan
- MUL 7 × -3 (0xFFFFFFFD): `result`=0xFFFFFFEB, `m_done` at T33 (T1 with `MULDIV_FAST_MUL_EN`), `m_busy` high T0..T32.
- MULH, MULHSU and MULHU with `op_a`=0x80000000, `op_b`=0xFFFFFFFF:
  - MULH returns 0x00000000.
  - MULHSU returns 0x80000000.
  - MULHU returns 0x7FFFFFFF.
- DIV -7/2: `result`=0xFFFFFFFD. REM -7/2: `result`=0xFFFFFFFF. DIVU 100/7: `result`=14. REMU 100/7: `result`=2.
- Boundary cases, each with `m_done` at T1:
  - DIV x/0 returns 0xFFFFFFFF.
  - REMU 0x1234/0 returns 0x1234.
  - DIV 0x80000000/-1 returns 0x80000000.
  - REM 0x80000000/-1 returns 0.
- `flush` at T10 of a DIV:
  - IDLE at T11.
  - No `m_done` pulse.
  - `m_busy` is 0 from T11.
  - A new DIVU 9/3 issued at T12 returns 3 at T45.
- `start` held high through DONE: exactly one `m_done` pulse, then IDLE. `reset` at T5 returns all outputs to 0 by T6.
